// File: rtl/iter_mul_pkg.sv
// Shared definitions for the iterative shift-add multiply-accumulate unit.
// Contents: FSM state enum and counter-width helper.
package iter_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Iteration counter width: clog2(w), never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/iter_mul_step.sv
// One shift-add iteration of the multiplier datapath (purely combinational).
// Optional feature macro: ITER_MUL_SIGNED_EN adds i_sub (subtract instead of add).
// Ports:
//   i_sub     subtract mcand instead of adding it (signed build only)
//   i_acc     running accumulator, 2W bits
//   i_mcand   shifted multiplicand, 2W bits
//   i_mplier  remaining multiplier bits, LSB is the current bit
//   o_acc     accumulator after this iteration
//   o_mcand   multiplicand shifted left by one
//   o_mplier  multiplier shifted right by one
module iter_mul_step #(
    parameter int unsigned W = 5
) (
`ifdef ITER_MUL_SIGNED_EN
    input  logic             i_sub,
`endif
    input  logic [2*W-1:0]   i_acc,
    input  logic [2*W-1:0]   i_mcand,
    input  logic [W-1:0]     i_mplier,
    output logic [2*W-1:0]   o_acc,
    output logic [2*W-1:0]   o_mcand,
    output logic [W-1:0]     o_mplier
);

    // Conditional add (or subtract for the negative-weight MSB) plus shifts.
    always_comb begin
        o_acc    = i_acc;
        o_mcand  = i_mcand << 1;
        o_mplier = i_mplier >> 1;
        if (i_mplier[0]) begin
`ifdef ITER_MUL_SIGNED_EN
            if (i_sub) begin
                o_acc = i_acc - i_mcand;
            end else begin
                o_acc = i_acc + i_mcand;
            end
`else
            o_acc = i_acc + i_mcand;
`endif
        end
    end

endmodule

// File: rtl/iter_mul_acc.sv
// Multicycle shift-add multiply-accumulate: p = a*b + c over d_width iterations.
// Rebuilds a divider's dividend from quotient/divisor/remainder.
// Optional feature macro: ITER_MUL_SIGNED_EN adds signed_op (two's-complement mode).
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      one-cycle request, operands sampled with it
//   a, b, c    multiplicand, multiplier, addend (d_width bits)
//   signed_op  two's-complement mode (signed build only)
//   p          registered 2*d_width result, valid from ready onward
//   busy       high while iterating
//   ready      one-cycle completion pulse
module iter_mul_acc
    import iter_mul_pkg::*;
#(
    parameter int unsigned d_width = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [d_width-1:0]     a,
    input  logic [d_width-1:0]     b,
    input  logic [d_width-1:0]     c,
`ifdef ITER_MUL_SIGNED_EN
    input  logic                   signed_op,
`endif
    output logic [2*d_width-1:0]   p,
    output logic                   busy,
    output logic                   ready
);

    localparam int unsigned W  = d_width;
    localparam int unsigned PW = 2 * W;
    localparam int unsigned CW = cnt_width(W);

    state_t          r_state;
    state_t          w_state_next;
    logic [PW-1:0]   r_mcand;
    logic [PW-1:0]   r_acc;
    logic [PW-1:0]   r_p;
    logic [W-1:0]    r_mplier;
    logic [CW-1:0]   r_cnt;

    logic            w_accept;
    logic            w_last;
    logic            w_a_fill;
    logic            w_c_fill;
    logic [PW-1:0]   w_acc_next;
    logic [PW-1:0]   w_mcand_next;
    logic [W-1:0]    w_mplier_next;

    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last   = (r_state == RUN) && (r_cnt == CW'(W - 1));

`ifdef ITER_MUL_SIGNED_EN
    logic r_signed;
    logic w_sub;

    // Sign-extension fill for a and c when the request is signed.
    assign w_a_fill = signed_op & a[W-1];
    assign w_c_fill = signed_op & c[W-1];
    // The multiplier MSB carries weight -2^(W-1) in signed mode.
    assign w_sub    = r_signed & w_last;
`else
    assign w_a_fill = 1'b0;
    assign w_c_fill = 1'b0;
`endif

    iter_mul_step #(
        .W (W)
    ) u_step (
`ifdef ITER_MUL_SIGNED_EN
        .i_sub    (w_sub),
`endif
        .i_acc    (r_acc),
        .i_mcand  (r_mcand),
        .i_mplier (r_mplier),
        .o_acc    (w_acc_next),
        .o_mcand  (w_mcand_next),
        .o_mplier (w_mplier_next)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; DONE with start re-enters RUN without a bubble.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_next = RUN;
            RUN:     if (w_last) w_state_next = DONE;
            DONE:    w_state_next = start ? RUN : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath registers: load on accept, iterate in RUN, capture result on last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_p      <= '0;
        end else if (w_accept) begin
            r_mcand  <= {{W{w_a_fill}}, a};
            r_mplier <= b;
            r_acc    <= {{W{w_c_fill}}, c};
            r_cnt    <= '0;
        end else if (r_state == RUN) begin
            r_mcand  <= w_mcand_next;
            r_mplier <= w_mplier_next;
            r_acc    <= w_acc_next;
            r_cnt    <= r_cnt + CW'(1);
            if (w_last) begin
                r_p <= w_acc_next;
            end
        end
    end

`ifdef ITER_MUL_SIGNED_EN
    // Mode latched with the operands so a mid-operation change has no effect.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_signed <= 1'b0;
        end else if (w_accept) begin
            r_signed <= signed_op;
        end
    end
`endif

    assign p     = r_p;
    assign busy  = (r_state == RUN);
    assign ready = (r_state == DONE);

endmodule

// File: tb/tb_iter_mul_acc.sv
// Directed self-checking bench for iter_mul_acc (d_width = 5).
module tb_iter_mul_acc;

    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [4:0]  c;
    logic [9:0]  p;
    logic        busy;
    logic        ready;
`ifdef ITER_MUL_SIGNED_EN
    logic        signed_op;
`endif

    int n_tests;
    int n_fail;

    iter_mul_acc #(
        .d_width (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .c         (c),
`ifdef ITER_MUL_SIGNED_EN
        .signed_op (signed_op),
`endif
        .p         (p),
        .busy      (busy),
        .ready     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, check 5 busy cycles, stop in the ready cycle.
    task automatic do_op(input logic [4:0] ta, input logic [4:0] tb, input logic [4:0] tc,
                         input logic [9:0] exp, input string tag);
        a     = ta;
        b     = tb;
        c     = tc;
        start = 1'b1;
        adv();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check({tag, "_busy"}, {30'd0, busy, ready}, 32'd2);
            adv();
        end
        check({tag, "_ready"}, {30'd0, busy, ready}, 32'd1);
        check({tag, "_p"}, {22'd0, p}, {22'd0, exp});
    endtask

    initial begin
        int n_ready;
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        c       = '0;
`ifdef ITER_MUL_SIGNED_EN
        signed_op = 1'b0;
`endif
        #1;
        for (int i = 0; i < 5; i++) adv();
        rst = 1'b0;
        check("reset_p", {22'd0, p}, 32'd0);
        check("reset_busy_ready", {30'd0, busy, ready}, 32'd0);

        // Basic: 2*13+1
        do_op(5'b00010, 5'b01101, 5'b00001, 10'd27, "basic");
        adv();
        check("idle_after_done", {30'd0, busy, ready}, 32'd0);
        check("p_hold", {22'd0, p}, 32'd27);

        // All ones: 31*31+31
        do_op(5'b11111, 5'b11111, 5'b11111, 10'd992, "ones");
        adv();

        // Zero operands
        do_op(5'd9, 5'd0, 5'd21, 10'd21, "b_zero");
        adv();
        do_op(5'd0, 5'd22, 5'd13, 10'd13, "a_zero");
        adv();
        do_op(5'd21, 5'd10, 5'd3, 10'd213, "mixed");

        // Back-to-back: new start in the ready cycle, stray start during RUN
        a     = 5'd3;
        b     = 5'd0;
        c     = 5'd7;
        start = 1'b1;
        adv();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("b2b_busy", {30'd0, busy, ready}, 32'd2);
            if (i == 1) begin
                a     = 5'd31;
                b     = 5'd31;
                c     = 5'd31;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            adv();
        end
        start = 1'b0;
        check("b2b_ready", {30'd0, busy, ready}, 32'd1);
        check("b2b_p", {22'd0, p}, 32'd7);
        adv();
        check("b2b_idle", {30'd0, busy, ready}, 32'd0);

        // Reset in the third RUN cycle
        a     = 5'd5;
        b     = 5'd5;
        c     = 5'd5;
        start = 1'b1;
        adv();
        start = 1'b0;
        adv();
        adv();
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        adv();
        rst = 1'b0;
        check("mid_rst_busy_ready", {30'd0, busy, ready}, 32'd0);
        check("mid_rst_p", {22'd0, p}, 32'd0);
        n_ready = 0;
        for (int i = 0; i < 8; i++) begin
            if (ready || busy) n_ready++;
            adv();
        end
        check("no_ready_after_rst", n_ready, 32'd0);

        // Reset coinciding with start: reset wins
        rst   = 1'b1;
        start = 1'b1;
        adv();
        rst   = 1'b0;
        start = 1'b0;
        check("rst_wins", {30'd0, busy, ready}, 32'd0);
        adv();

        // Unsigned 3*29
        do_op(5'b00011, 5'b11101, 5'b00000, 10'd87, "unsigned_87");
        adv();

`ifdef ITER_MUL_SIGNED_EN
        signed_op = 1'b1;
        do_op(5'b11110, 5'b01101, 5'b00001, 10'b1111100111, "signed_m25");
        adv();
        do_op(5'b00011, 5'b11101, 5'b00000, 10'b1111110111, "signed_m9");
        adv();
        signed_op = 1'b0;
        do_op(5'b00011, 5'b11101, 5'b00000, 10'd87, "signed_off_87");
        adv();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
